// File: rtl/apple_kb_latch_if.sv
// 6502 bus slice seen by the keyboard register: address/strobe in, read data out.
// Master is the CPU side, slave is the keyboard latch.
interface apple_kb_latch_if;
    logic [15:0] addr;
    logic        rw;
    logic        bus_en;
    logic [7:0]  dout;
    logic        dout_valid;

    modport master (
        output addr,
        output rw,
        output bus_en,
        input  dout,
        input  dout_valid
    );

    modport slave (
        input  addr,
        input  rw,
        input  bus_en,
        output dout,
        output dout_valid
    );
endinterface

// File: rtl/apple_kb_latch.sv
// Apple IIe keyboard latch: debounce HID code, map to Apple ASCII, strobe + auto-repeat, serve KBD/KBDSTRB.
// Latency: latch 1 cycle after debounce acceptance, bus reads 1 cycle; no backpressure (bus_en is a pulse, always served).
module apple_kb_latch #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 3_333_333
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        keycode,
    apple_kb_latch_if.slave   bus,
    output logic              key_strobe,
    output logic [6:0]        key_ascii,
    output logic              any_key_down,
    output logic              caps_lock
);

    localparam int             SW           = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [SW-1:0]  STAB_MAX     = SW'(DEBOUNCE_CYCLES);
    localparam logic [SW-1:0]  STAB_LAST    = SW'(DEBOUNCE_CYCLES - 1);
    localparam logic [24:0]    DELAY_LAST   = 25'(REPEAT_DELAY - 1);
    localparam logic [24:0]    PERIOD_LAST  = 25'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    state_t        state, state_nx;
    logic [24:0]   rpt_cnt, rpt_nx;
    logic [7:0]    kc_q, kc_stable, held_code;
    logic [SW-1:0] stab_cnt;
    logic          acc;
    logic          lat;
    logic [7:0]    map;
    logic          map_vld;
    logic [6:0]    map_ascii;
    logic          kbd_rd, strb_hit, strb_rd;

    // Returns {mapped, ascii}; every mapped code yields a non-zero ascii value.
    function automatic logic [7:0] map_key(input logic [7:0] code, input logic caps);
        logic [7:0] r;
        r = 8'h00;
        if (code >= 8'h04 && code <= 8'h1D)
            r = code + (caps ? 8'h3D : 8'h5D);
        else if (code >= 8'h1E && code <= 8'h26)
            r = code + 8'h13;
        else begin
            case (code)
                8'h27:   r = 8'h30;
                8'h28:   r = 8'h0D;
                8'h29:   r = 8'h1B;
                8'h2A:   r = 8'h08;
                8'h2B:   r = 8'h09;
                8'h2C:   r = 8'h20;
                8'h4F:   r = 8'h15;
                8'h50:   r = 8'h08;
                8'h51:   r = 8'h0A;
                8'h52:   r = 8'h0B;
                default: r = 8'h00;
            endcase
        end
        return {(r != 8'h00), r[6:0]};
    endfunction

    // acc is a one-cycle pulse: the stability counter saturates, so each stable run is accepted once.
    always_ff @(posedge clk) begin
        if (reset) begin
            kc_q      <= 8'h00;
            kc_stable <= 8'h00;
            stab_cnt  <= '0;
            acc       <= 1'b0;
        end else begin
            kc_q <= keycode;
            acc  <= 1'b0;
            if (keycode != kc_q) begin
                stab_cnt <= '0;
            end else if (stab_cnt != STAB_MAX) begin
                stab_cnt <= stab_cnt + 1'b1;
                if (stab_cnt == STAB_LAST) begin
                    kc_stable <= kc_q;
                    acc       <= 1'b1;
                end
            end
        end
    end

    assign map       = map_key(kc_stable, caps_lock);
    assign map_vld   = map[7];
    assign map_ascii = map[6:0];

    always_comb begin
        state_nx = state;
        rpt_nx   = rpt_cnt;
        lat      = 1'b0;
        case (state)
            IDLE: begin
                if (acc && map_vld) begin
                    lat      = 1'b1;
                    rpt_nx   = '0;
                    state_nx = DELAY;
                end
            end
            DELAY, REPEAT: begin
                if (acc && !map_vld) begin
                    rpt_nx   = '0;
                    state_nx = IDLE;
                end else if (acc && kc_stable != held_code) begin
                    lat      = 1'b1;
                    rpt_nx   = '0;
                    state_nx = DELAY;
                end else if (rpt_cnt == ((state == DELAY) ? DELAY_LAST : PERIOD_LAST)) begin
                    lat      = 1'b1;
                    rpt_nx   = '0;
                    state_nx = REPEAT;
                end else begin
                    rpt_nx = rpt_cnt + 25'd1;
                end
            end
            default: begin
                rpt_nx   = '0;
                state_nx = IDLE;
            end
        endcase
    end

    assign kbd_rd   = bus.bus_en && bus.rw && (bus.addr[15:4] == 12'hC00);
    assign strb_hit = bus.bus_en && (bus.addr[15:4] == 12'hC01);
    assign strb_rd  = strb_hit && bus.rw;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            rpt_cnt        <= '0;
            held_code      <= 8'h00;
            key_ascii      <= 7'h00;
            key_strobe     <= 1'b0;
            caps_lock      <= 1'b1;
            bus.dout       <= 8'h00;
            bus.dout_valid <= 1'b0;
        end else begin
            state   <= state_nx;
            rpt_cnt <= rpt_nx;
            if (lat) begin
                key_ascii <= map_ascii;
                held_code <= kc_stable;
            end
            // A new key must never be lost to a concurrent KBDSTRB access.
            if (lat)
                key_strobe <= 1'b1;
            else if (strb_hit)
                key_strobe <= 1'b0;
            if (acc && kc_stable == 8'h39)
                caps_lock <= ~caps_lock;
            bus.dout_valid <= kbd_rd || strb_rd;
            if (kbd_rd)
                bus.dout <= {key_strobe, key_ascii};
            else if (strb_rd)
                bus.dout <= {any_key_down, key_ascii};
        end
    end

    assign any_key_down = (state != IDLE);

endmodule

// File: tb/tb_apple_kb_latch.sv
// Bench for apple_kb_latch: directed scenarios plus random keys/bus traffic against a key-event model.
module tb_apple_kb_latch;
    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] keycode;
    logic       key_strobe;
    logic [6:0] key_ascii;
    logic       any_key_down;
    logic       caps_lock;

    apple_kb_latch_if bus ();

    apple_kb_latch #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .keycode      (keycode),
        .bus          (bus),
        .key_strobe   (key_strobe),
        .key_ascii    (key_ascii),
        .any_key_down (any_key_down),
        .caps_lock    (caps_lock)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: Apple ASCII for a HID usage, or -1 when the code is not a key.
    function automatic int ref_map(input logic [7:0] c, input bit caps);
        if (c >= 8'h04 && c <= 8'h1D) return (caps ? 65 : 97) + int'(c) - 4;
        if (c >= 8'h1E && c <= 8'h26) return 49 + int'(c) - 30;
        case (c)
            8'h27:   return 48;
            8'h28:   return 13;
            8'h29:   return 27;
            8'h2A:   return 8;
            8'h2B:   return 9;
            8'h2C:   return 32;
            8'h4F:   return 21;
            8'h50:   return 8;
            8'h51:   return 10;
            8'h52:   return 11;
            default: return -1;
        endcase
    endfunction

    // Model state: what the keyboard "knows" after each clock edge.
    logic [7:0] m_prev;
    int         m_run;
    bit         m_pend;
    logic [7:0] m_pend_code;
    bit         m_held, m_rep, m_strobe, m_caps;
    logic [7:0] m_code;
    logic [6:0] m_ascii;
    int         m_since;
    logic [7:0] exp_q[$];

    bit         rd_kbd, hit_strb, lat, tick_it;
    int         a;

    always @(posedge clk) begin
        if (reset) begin
            m_prev = 8'h00; m_run = 1; m_pend = 0; m_held = 0; m_rep = 0;
            m_strobe = 0; m_caps = 1; m_ascii = 7'h00; m_code = 8'h00; m_since = 0;
            exp_q.delete();
        end else begin
            rd_kbd   = bus.bus_en && bus.rw && (bus.addr >= 16'hC000) && (bus.addr <= 16'hC00F);
            hit_strb = bus.bus_en && (bus.addr >= 16'hC010) && (bus.addr <= 16'hC01F);
            if (rd_kbd) exp_q.push_back({m_strobe, m_ascii});
            else if (hit_strb && bus.rw) exp_q.push_back({m_held, m_ascii});

            lat = 0;
            tick_it = m_held;
            if (m_pend) begin
                a = ref_map(m_pend_code, m_caps);
                if (m_pend_code == 8'h39) m_caps = !m_caps;
                if (a < 0) begin
                    m_held = 0;
                    tick_it = 0;
                end else if (!m_held || m_pend_code != m_code) begin
                    m_ascii = 7'(a); m_code = m_pend_code; m_held = 1;
                    m_rep = 0; m_since = 0; lat = 1; tick_it = 0;
                end
            end
            if (tick_it) begin
                m_since++;
                if (m_since == (m_rep ? RP : RD)) begin
                    m_ascii = 7'(ref_map(m_code, m_caps));
                    m_rep = 1; m_since = 0; lat = 1;
                end
            end
            if (lat) m_strobe = 1;
            else if (hit_strb) m_strobe = 0;

            if (keycode == m_prev) begin
                if (m_run < DEB + 2) m_run++;
            end else begin
                m_prev = keycode;
                m_run = 1;
            end
            m_pend = (m_run == DEB + 1);
            m_pend_code = m_prev;
        end
    end

    // Monitor: status outputs every cycle, read data whenever the DUT presents it.
    always @(negedge clk) begin
        chk("strobe", key_strobe, m_strobe);
        chk("ascii", key_ascii, m_ascii);
        chk("any_key_down", any_key_down, m_held);
        chk("caps_lock", caps_lock, m_caps);
        if (bus.dout_valid || exp_q.size() > 0) begin
            chk("dout_valid", bus.dout_valid, (exp_q.size() > 0));
            if (bus.dout_valid && exp_q.size() > 0) chk("dout", bus.dout, exp_q[0]);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic access(input logic [15:0] ad, input logic r);
        bus.addr = ad; bus.rw = r; bus.bus_en = 1'b1;
        tick(1);
        bus.bus_en = 1'b0;
    endtask

    logic [7:0]  keys  [9] = '{8'h00, 8'h04, 8'h05, 8'h1E, 8'h27, 8'h2C, 8'h39, 8'h3A, 8'h50};
    logic [15:0] addrs [8] = '{16'hC000, 16'hC00F, 16'hC010, 16'hC01F, 16'hC011, 16'hC020, 16'hBFF0, 16'h0000};

    initial begin
        reset = 1'b1; keycode = 8'h00;
        bus.addr = 16'h0000; bus.rw = 1'b1; bus.bus_en = 1'b0;
        tick(2);
        chk("rst_strobe", key_strobe, 0);
        chk("rst_ascii", key_ascii, 0);
        chk("rst_any", any_key_down, 0);
        chk("rst_caps", caps_lock, 1);
        chk("rst_dout", bus.dout, 0);
        chk("rst_dout_valid", bus.dout_valid, 0);
        reset = 1'b0;
        tick(6);

        // Press 'a' key: latches 5 cycles after the first edge that sees it.
        keycode = 8'h04;
        tick(5);
        chk("t1_early", key_strobe, 0);
        tick(1);
        chk("t1_strobe", key_strobe, 1);
        chk("t1_ascii", key_ascii, 7'h41);
        tick(3);
        access(16'hC000, 1'b1);
        chk("t1_rd_valid", bus.dout_valid, 1);
        chk("t1_rd_dout", bus.dout, 8'hC1);

        access(16'hC010, 1'b0);
        chk("t3_clr", key_strobe, 0);
        access(16'hC000, 1'b1);
        chk("t3_kbd", bus.dout, 8'h41);
        access(16'hC011, 1'b1);
        chk("t3_strb_rd", bus.dout, 8'hC1);
        keycode = 8'h00;
        tick(8);
        chk("t3_release", any_key_down, 0);

        keycode = 8'h05; tick(3);
        keycode = 8'h00; tick(8);
        chk("t2_no_strobe", key_strobe, 0);
        chk("t2_ascii", key_ascii, 7'h41);

        // Repeat with a KBDSTRB write every cycle: strobe is visible only on re-latch cycles.
        keycode = 8'h2C;
        tick(6);
        chk("t4_latch", key_ascii, 7'h20);
        for (int i = 1; i <= 45; i++) begin
            access(16'hC010, 1'b0);
            chk($sformatf("t4_rep%0d", i), key_strobe,
                (i == RD || i == RD + RP || i == RD + 2*RP || i == RD + 3*RP));
        end
        keycode = 8'h00;
        tick(8);
        chk("t4_idle", any_key_down, 0);

        keycode = 8'h39; tick(8);
        keycode = 8'h00; tick(8);
        chk("t5_caps", caps_lock, 0);
        keycode = 8'h04; tick(6);
        chk("t5_lower", key_ascii, 7'h61);
        keycode = 8'h00; tick(8);
        access(16'hC010, 1'b0);
        keycode = 8'h3A; tick(8);
        chk("t5_unmapped_strobe", key_strobe, 0);
        chk("t5_unmapped_any", any_key_down, 0);
        keycode = 8'h00; tick(8);

        // Reset while repeating; key still held afterwards is a fresh press.
        keycode = 8'h04; tick(6);
        tick(25);
        access(16'hC000, 1'b1);
        chk("t6_repeat", any_key_down, 1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("t6_strobe", key_strobe, 0);
        chk("t6_ascii", key_ascii, 0);
        chk("t6_any", any_key_down, 0);
        chk("t6_caps", caps_lock, 1);
        chk("t6_dout", bus.dout, 0);
        chk("t6_dout_valid", bus.dout_valid, 0);
        tick(5);
        chk("t6_relatch_early", key_strobe, 0);
        tick(1);
        chk("t6_relatch", key_strobe, 1);
        chk("t6_relatch_ascii", key_ascii, 7'h41);

        for (int seg = 0; seg < 120; seg++) begin
            keycode = keys[$urandom_range(0, 8)];
            for (int c = 0; c < int'($urandom_range(1, 40)); c++) begin
                if ($urandom_range(0, 3) == 0)
                    access(addrs[$urandom_range(0, 7)], 1'($urandom_range(0, 1)));
                else
                    tick(1);
            end
            if ($urandom_range(0, 59) == 0) begin
                reset = 1'b1;
                tick(1);
                reset = 1'b0;
            end
        end
        keycode = 8'h00;
        tick(4);
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
